nco_period_meter: RTL and testbench
===================================

Name: nco_period_meter

Overview:
- Receive-side counterpart to the NCO sine output. Consumes the 8-bit offset-binary sample stream and measures the waveform period in clock cycles.
- Uses hysteresis zero-crossing detection and averages over 2^AVG_LOG2 periods.
- Used to close the loop on NCO tuning words and to verify the DAC path in hardware.

Parameters:
- DW, 8: sample width, unsigned offset-binary.
- MID, 128: midscale (zero) code.
- HYST, 8: hysteresis half-width in codes; must satisfy 0 < HYST < MID.
- CW, 24: period counter / result width.
- AVG_LOG2, 2: average over 2^AVG_LOG2 consecutive periods (range 0..4).

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: synchronous active-low reset, sampled on rising clk.
- sample_in, input, DW: sample, qualified by sample_valid.
- sample_valid, input, 1: sample_in accepted on any clk edge where this is high; no backpressure.
- period_out, output, CW: averaged period in clk cycles.
- period_valid, output, 1: one-cycle pulse when period_out updates.
- locked, output, 1: high once at least one average has completed without an intervening overflow.
- overflow, output, 1: sticky; set when the period counter saturates.

Behaviour:
- Reset (rst_n=0 at a clk edge): all of the following clear to 0 — period_out, period_valid, locked, overflow, counter, accumulator and averaging count. Hysteresis state is forced to UNKNOWN and the FSM to IDLE. Reset takes priority over all other events, including mid-measurement.
- Hysteresis classifier, evaluated only on accepted samples:
  - sample_in <= MID-HYST → LOW.
  - sample_in >= MID+HYST → HIGH.
  - Otherwise the previous level is held.
- Rising edge event: an accepted sample moves the level from LOW to HIGH. UNKNOWN→HIGH is not an edge.
- Period counter: clears to 0 on the edge cycle and increments by 1 on every other clk cycle, regardless of sample_valid. Period = counter+1 at the next edge, i.e. the clk-cycle distance between edge samples.
- Counter saturation: the counter saturates at 2^CW-1. On reaching saturation:
  - set overflow and clear locked;
  - discard the accumulator and averaging count;
  - FSM goes to ARM with the level forced UNKNOWN.
- FSM:
  - IDLE: wait for an accepted LOW sample → ARM.
  - ARM: on a rising edge, clear the counter, acc=0, n=0 → MEASURE. No output.
  - MEASURE, on each rising edge:
    - acc += counter+1, n += 1, counter cleared.
    - When n reaches 2^AVG_LOG2: period_out <= (acc+counter+1) >> AVG_LOG2 (truncating), period_valid=1 on the next cycle, locked=1, acc=0, n=0. Stay in MEASURE.
- Latency: period_valid is high exactly one clk after the edge-sample acceptance edge that completes an average. period_out holds its value until the next update or reset.
- Width: the accumulator is CW+AVG_LOG2 bits, so the sum cannot overflow before the counter saturates.
- overflow clears only on reset. A later successful average sets locked again but does not clear overflow.
- Same-cycle edge and saturation: saturation wins; the edge is ignored.

Optional Feature:
- Macro: PERIOD_METER_MINMAX_EN.
- Defined:
  - Adds outputs period_min [CW-1:0] (reset value all-ones) and period_max [CW-1:0] (reset value 0).
  - Both update on every single-period measurement in MEASURE, i.e. unaveraged counter+1, including periods that are not the last of an average.
  - Neither updates on overflow.
- Undefined: the ports and logic are absent; the remaining behaviour is identical.

Test Plan:
- Reset, then square stream, sample_valid=1 every cycle (120×0x00 then 120×0xFF, repeated), defaults → first period_valid 240·4 cycles after the first rising edge; period_out=240; locked=1; overflow=0.
- Same stream with sample_valid high every other cycle (each sample held 2 clks, 240 accepted samples per period) → period_out=480.
- Starting from LOW, alternate samples 126/130/126/130 for 1000 cycles, then 0xFF → no edge until 0xFF; no period_valid during the toggling.
- Generic override CW=8; hold 0x00, edge to 0xFF, then hold 0xFF for 300 cycles → overflow=1 at counter 255, locked=0, no period_valid. A following valid 240-cycle stream gives period_out=240 and locked=1 while overflow stays 1.
- Assert rst_n=0 for 1 cycle midway through the third period of an average → all outputs 0. The next result needs a LOW, an arming edge and 4 full periods.
- With PERIOD_METER_MINMAX_EN: alternate periods 200 and 280 → period_out=240, period_min=200, period_max=280.

Source files
------------

// File: rtl/nco_period_meter.sv
// Hysteresis zero-crossing period meter for the NCO sample stream.
// Define PERIOD_METER_MINMAX_EN to add period_min/period_max outputs.
module nco_period_meter #(
  parameter int DW       = 8,
  parameter int MID      = 128,
  parameter int HYST     = 8,
  parameter int CW       = 24,
  parameter int AVG_LOG2 = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] sample_in,
  input  logic          sample_valid,
  output logic [CW-1:0] period_out,
  output logic          period_valid,
  output logic          locked,
`ifdef PERIOD_METER_MINMAX_EN
  output logic [CW-1:0] period_min,
  output logic [CW-1:0] period_max,
`endif
  output logic          overflow
);

  localparam int AW = CW + AVG_LOG2;
  localparam int NW = AVG_LOG2 + 1;

  localparam logic [CW-1:0] CMAX  = '1;
  localparam logic [NW-1:0] NLAST =
    NW'((1 << AVG_LOG2) - 1);
  localparam logic [DW-1:0] LO_TH = DW'(MID - HYST);
  localparam logic [DW-1:0] HI_TH = DW'(MID + HYST);

  typedef enum logic [1:0] {
    LV_UNK,
    LV_LOW,
    LV_HIGH
  } level_t;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  level_t        level;
  level_t        level_nx;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] acc;
  logic [NW-1:0] n;

  logic          is_low;
  logic          is_high;
  logic          rise;
  logic          sat;
  logic [CW-1:0] per;
  logic [AW-1:0] sum;
  logic [CW-1:0] avg;

  always_comb begin
    is_low   = (sample_in <= LO_TH);
    is_high  = (sample_in >= HI_TH);
    level_nx = level;
    if (sample_valid) begin
      if (is_low)
        level_nx = LV_LOW;
      else if (is_high)
        level_nx = LV_HIGH;
    end
    rise = sample_valid && is_high &&
           (level == LV_LOW);
    sat  = (state == MEASURE) && (cnt == CMAX);
    per  = cnt + 1'b1;
    sum  = acc + AW'(per);
    avg  = CW'(sum >> AVG_LOG2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      level        <= LV_UNK;
      cnt          <= '0;
      acc          <= '0;
      n            <= '0;
      period_out   <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      level        <= level_nx;

      // Saturation outranks a coincident edge.
      if (rise && !sat)
        cnt <= '0;
      else if (cnt != CMAX)
        cnt <= cnt + 1'b1;

      if (sat) begin
        overflow <= 1'b1;
        locked   <= 1'b0;
        acc      <= '0;
        n        <= '0;
        level    <= LV_UNK;
        state    <= ARM;
      end else begin
        unique case (state)
          IDLE: begin
            if (sample_valid && is_low)
              state <= ARM;
          end
          ARM: begin
            if (rise) begin
              acc   <= '0;
              n     <= '0;
              state <= MEASURE;
            end
          end
          MEASURE: begin
            if (rise) begin
              if (n == NLAST) begin
                period_out   <= avg;
                period_valid <= 1'b1;
                locked       <= 1'b1;
                acc          <= '0;
                n            <= '0;
              end else begin
                acc <= sum;
                n   <= n + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef PERIOD_METER_MINMAX_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_min <= '1;
      period_max <= '0;
    end else if (state == MEASURE &&
                 rise && !sat) begin
      if (per < period_min)
        period_min <= per;
      if (per > period_max)
        period_max <= per;
    end
  end
`endif

endmodule

// File: tb/tb_nco_period_meter.sv
// Scoreboard bench for nco_period_meter: default instance
// plus a CW=8 instance for the saturation path.
module tb_nco_period_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rst8_n;
  logic [7:0]  s;
  logic        sv;

  logic [23:0] po;
  logic        pv, lk, ov;
  logic [7:0]  po8;
  logic        pv8, lk8, ov8;
`ifdef PERIOD_METER_MINMAX_EN
  logic [23:0] pmin, pmax;
  logic [7:0]  pmin8, pmax8;
`endif

  nco_period_meter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (s),
    .sample_valid (sv),
    .period_out   (po),
    .period_valid (pv),
    .locked       (lk),
`ifdef PERIOD_METER_MINMAX_EN
    .period_min   (pmin),
    .period_max   (pmax),
`endif
    .overflow     (ov)
  );

  nco_period_meter #(.CW(8)) dut8 (
    .clk          (clk),
    .rst_n        (rst8_n),
    .sample_in    (s),
    .sample_valid (sv),
    .period_out   (po8),
    .period_valid (pv8),
    .locked       (lk8),
`ifdef PERIOD_METER_MINMAX_EN
    .period_min   (pmin8),
    .period_max   (pmax8),
`endif
    .overflow     (ov8)
  );

  typedef struct {
    logic [23:0] per;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t q8[$];
  exp_t e;
  exp_t e8;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d",
               nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (pv === 1'b1) begin
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL spurious period_valid: got po=%0d, expected none",
                 po);
      end else begin
        e = q.pop_front();
        chk("period_out", 32'(po), 32'(e.per));
        chk("locked@valid", 32'(lk), 32'd1);
        chk("overflow@valid", 32'(ov), 32'(e.ovf));
        chk("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (pv8 === 1'b1) begin
      if (q8.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL spurious period_valid8: got po=%0d, expected none",
                 po8);
      end else begin
        e8 = q8.pop_front();
        chk("period_out8", 32'(po8), 32'(e8.per[7:0]));
        chk("locked8@valid", 32'(lk8), 32'd1);
        chk("overflow8@valid", 32'(ov8), 32'(e8.ovf));
        chk("latency8", 32'(cyc), 32'(e8.cyc));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic drv(input logic [7:0] v,
                     input logic val);
    s  = v;
    sv = val;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [7:0] v,
                     input int len,
                     input bit half);
    for (int i = 0; i < len; i++) begin
      if (half) begin
        drv(v, 1'b1);
        drv(v, 1'b0);
      end else begin
        drv(v, 1'b1);
      end
    end
  endtask

  task automatic pair(input int lo, input int hi,
                      input bit half);
    run(8'h00, lo, half);
    run(8'hFF, hi, half);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drv(8'h00, 1'b0);
    drv(8'h00, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic push(input int per, input bit ovf,
                      input int at);
    q.push_back('{per: 24'(per), ovf: ovf, cyc: at});
  endtask

  int t;

  initial begin
    rst_n  = 1'b0;
    rst8_n = 1'b0;
    s      = 8'h00;
    sv     = 1'b0;
    repeat (3) drv(8'h00, 1'b0);

    chk("reset period_out", 32'(po), 32'd0);
    chk("reset period_valid", 32'(pv), 32'd0);
    chk("reset locked", 32'(lk), 32'd0);
    chk("reset overflow", 32'(ov), 32'd0);
    chk("reset8 overflow", 32'(ov8), 32'd0);
`ifdef PERIOD_METER_MINMAX_EN
    chk("reset period_min", 32'(pmin), 32'hFFFFFF);
    chk("reset period_max", 32'(pmax), 32'd0);
`endif

    // full-rate square wave, 240-cycle period
    rst_n = 1'b1;
    run(8'h00, 120, 1'b0);
    drv(8'hFF, 1'b1);
    t = cyc;
    push(240, 1'b0, t + 960);
    run(8'hFF, 119, 1'b0);
    repeat (4) pair(120, 120, 1'b0);
    chk("locked after avg", 32'(lk), 32'd1);
    chk("overflow after avg", 32'(ov), 32'd0);
    chk("period_out held", 32'(po), 32'd240);

    // every-other-cycle valid, 480-cycle period
    do_reset();
    run(8'h00, 120, 1'b1);
    drv(8'hFF, 1'b1);
    t = cyc;
    drv(8'hFF, 1'b0);
    push(480, 1'b0, t + 1920);
    run(8'hFF, 119, 1'b1);
    repeat (4) pair(120, 120, 1'b1);

    // in-band toggling never makes an edge
    do_reset();
    run(8'h00, 10, 1'b0);
    for (int i = 0; i < 500; i++) begin
      drv(8'd126, 1'b1);
      drv(8'd130, 1'b1);
    end
    chk("locked during toggle", 32'(lk), 32'd0);
    drv(8'hFF, 1'b1);
    t = cyc;
    push(240, 1'b0, t + 960);
    run(8'hFF, 119, 1'b0);
    repeat (4) pair(120, 120, 1'b0);

    // reset midway through the third period
    repeat (2) pair(120, 120, 1'b0);
    run(8'h00, 60, 1'b0);
    chk("pre-reset period_out", 32'(po), 32'd240);
    chk("pre-reset locked", 32'(lk), 32'd1);
    rst_n = 1'b0;
    drv(8'h00, 1'b1);
    rst_n = 1'b1;
    chk("midreset period_out", 32'(po), 32'd0);
    chk("midreset period_valid", 32'(pv), 32'd0);
    chk("midreset locked", 32'(lk), 32'd0);
    chk("midreset overflow", 32'(ov), 32'd0);
    run(8'h00, 59, 1'b0);
    drv(8'hFF, 1'b1);
    t = cyc;
    push(240, 1'b0, t + 960);
    run(8'hFF, 119, 1'b0);
    repeat (4) pair(120, 120, 1'b0);

    // alternating 200 / 280 periods
    do_reset();
    run(8'h00, 100, 1'b0);
    drv(8'hFF, 1'b1);
    t = cyc;
    push(240, 1'b0, t + 960);
    run(8'hFF, 99, 1'b0);
    pair(100, 140, 1'b0);
    pair(140, 100, 1'b0);
    pair(100, 140, 1'b0);
    pair(140, 100, 1'b0);
`ifdef PERIOD_METER_MINMAX_EN
    chk("period_min", 32'(pmin), 32'd200);
    chk("period_max", 32'(pmax), 32'd280);
`endif

    // CW=8 saturation, then recovery
    rst_n  = 1'b0;
    rst8_n = 1'b1;
    run(8'h00, 10, 1'b0);
    drv(8'hFF, 1'b1);
    run(8'hFF, 255, 1'b0);
    chk("ovf8 before sat", 32'(ov8), 32'd0);
    chk("locked8 before sat", 32'(lk8), 32'd0);
    drv(8'hFF, 1'b1);
    chk("ovf8 at sat", 32'(ov8), 32'd1);
    run(8'hFF, 43, 1'b0);
    chk("ovf8 sticky", 32'(ov8), 32'd1);
    chk("locked8 after sat", 32'(lk8), 32'd0);
    run(8'h00, 120, 1'b0);
    drv(8'hFF, 1'b1);
    t = cyc;
    q8.push_back('{per: 24'd240, ovf: 1'b1,
                   cyc: t + 960});
    run(8'hFF, 119, 1'b0);
    repeat (4) pair(120, 120, 1'b0);
    chk("locked8 recovered", 32'(lk8), 32'd1);
    chk("ovf8 still set", 32'(ov8), 32'd1);
    chk("period_out8 held", 32'(po8), 32'd240);

    repeat (5) drv(8'h00, 1'b0);
    chk("pending results", 32'(q.size()), 32'd0);
    chk("pending results8", 32'(q8.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
